// File: rtl/scan_seq_ctrl.sv
// Scan test sequencer: streams load/expected/mask words into the scan chain,
// overlaps unload of pattern k with load of pattern k+1, and checks the response.
module scan_seq_ctrl #(
    parameter int NREGS      = 1918,
    parameter int CAP_CYCLES = 1,
    parameter int OUT_LAT    = 1
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [15:0] num_pat_i,
    input  logic        pat_valid_i,
    output logic        pat_ready_o,
    input  logic        pat_in_i,
    input  logic        pat_exp_i,
    input  logic        pat_mask_i,
    output logic        test_tm_o,
    output logic        test_se_o,
    output logic        scan_in_o,
    input  logic        scan_out_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        fail_o,
    output logic [15:0] err_cnt_o
);

    localparam int BW     = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int STAGES = OUT_LAT + 1;
    localparam int CMAX   = (CAP_CYCLES > STAGES) ? CAP_CYCLES : STAGES;
    localparam int CW     = $clog2(CMAX + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NREGS - 1);
    localparam logic [CW-1:0] CAP_LAST = CW'(CAP_CYCLES - 1);
    localparam logic [CW-1:0] DRN_LAST = CW'(OUT_LAT);

    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_CAPTURE, S_DRAIN, S_DONE} state_t;

    state_t        r_state, w_nxt;
    logic [BW-1:0] r_bit_cnt;
    logic [15:0]   r_pat_cnt;
    logic [15:0]   r_num_pat;
    logic [CW-1:0] r_cnt;
    logic          r_se, r_si, r_done, r_fail;
    logic [15:0]   r_err;
    logic [STAGES:1] r_vld_pipe, r_exp_pipe, r_msk_pipe;

    logic w_ready, w_busy, w_acc, w_start, w_bit_last, w_last_pat, w_mism, w_msk_in;

    // The done_o cycle still counts as busy, so a start there is ignored.
    assign w_start    = (r_state == S_IDLE) && !r_done && start_i && !abort_i;
    assign w_acc      = pat_valid_i && w_ready;
    assign w_bit_last = (r_bit_cnt == BIT_LAST);
    assign w_last_pat = (r_pat_cnt == r_num_pat);
    // The first pass only loads; whatever leaves the chain then is stale.
    assign w_msk_in   = pat_mask_i || (r_pat_cnt == 16'd0);
    assign w_mism     = r_vld_pipe[STAGES] && !r_msk_pipe[STAGES] &&
                        (scan_out_i != r_exp_pipe[STAGES]) && !abort_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_state <= S_IDLE;
        else         r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        if (abort_i) begin
            w_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (w_start) w_nxt = (num_pat_i == 16'd0) ? S_DONE : S_SHIFT;
                S_SHIFT:   if (w_acc && w_bit_last) w_nxt = w_last_pat ? S_DRAIN : S_CAPTURE;
                S_CAPTURE: if (r_cnt == CAP_LAST) w_nxt = S_SHIFT;
                S_DRAIN:   if (r_cnt == DRN_LAST) w_nxt = S_DONE;
                S_DONE:    w_nxt = S_IDLE;
                default:   w_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_ready = (r_state == S_SHIFT);
        w_busy  = (r_state != S_IDLE) || r_done;
    end

    assign pat_ready_o = w_ready;
    assign busy_o      = w_busy;
    assign test_tm_o   = w_busy;
    assign test_se_o   = r_se;
    assign scan_in_o   = r_si;
    assign done_o      = r_done;
    assign fail_o      = r_fail;
    assign err_cnt_o   = r_err;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_bit_cnt <= '0;
            r_pat_cnt <= '0;
            r_num_pat <= '0;
            r_cnt     <= '0;
        end else begin
            if (w_start) begin
                r_bit_cnt <= '0;
                r_pat_cnt <= '0;
                r_num_pat <= num_pat_i;
            end else begin
                if (w_acc) r_bit_cnt <= w_bit_last ? '0 : r_bit_cnt + 1'b1;
                if (r_state == S_CAPTURE && r_cnt == CAP_LAST && !abort_i)
                    r_pat_cnt <= r_pat_cnt + 16'd1;
            end
            if (r_state != w_nxt)
                r_cnt <= '0;
            else if (r_state == S_CAPTURE || r_state == S_DRAIN)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // Stall cycles drop se so the chain holds; scan-in keeps its last bit.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_se <= 1'b0;
            r_si <= 1'b0;
        end else begin
            r_se <= w_acc && !abort_i;
            if (w_acc && !abort_i) r_si <= pat_in_i;
        end
    end

    // Expected/mask ride alongside the shift so they meet scan_out_i OUT_LAT after se-high.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_vld_pipe <= '0;
            r_exp_pipe <= '0;
            r_msk_pipe <= '0;
        end else if (abort_i) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe[1] <= w_acc;
            r_exp_pipe[1] <= pat_exp_i;
            r_msk_pipe[1] <= w_msk_in;
            for (int k = 2; k <= STAGES; k++) begin
                r_vld_pipe[k] <= r_vld_pipe[k-1];
                r_exp_pipe[k] <= r_exp_pipe[k-1];
                r_msk_pipe[k] <= r_msk_pipe[k-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_done <= 1'b0;
            r_fail <= 1'b0;
            r_err  <= '0;
        end else begin
            r_done <= (r_state == S_DONE) && !abort_i;
            if (w_start) begin
                r_fail <= 1'b0;
                r_err  <= '0;
            end else if (w_mism) begin
                r_fail <= 1'b1;
                if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Directed bench for scan_seq_ctrl: 8-flop chain model with output flop,
// expected responses derived from the bits the bench itself loaded.
module tb_scan_seq_ctrl;
    localparam int N   = 8;
    localparam int CAP = 1;
    localparam int OL  = 1;

    logic        clk_i, rstn_i, start_i, abort_i;
    logic [15:0] num_pat_i;
    logic        pat_valid_i, pat_ready_o, pat_in_i, pat_exp_i, pat_mask_i;
    logic        test_tm_o, test_se_o, scan_in_o, scan_out_i;
    logic        busy_o, done_o, fail_o;
    logic [15:0] err_cnt_o;

    scan_seq_ctrl #(.NREGS(N), .CAP_CYCLES(CAP), .OUT_LAT(OL)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .abort_i(abort_i),
        .num_pat_i(num_pat_i), .pat_valid_i(pat_valid_i), .pat_ready_o(pat_ready_o),
        .pat_in_i(pat_in_i), .pat_exp_i(pat_exp_i), .pat_mask_i(pat_mask_i),
        .test_tm_o(test_tm_o), .test_se_o(test_se_o), .scan_in_o(scan_in_o),
        .scan_out_i(scan_out_i), .busy_o(busy_o), .done_o(done_o),
        .fail_o(fail_o), .err_cnt_o(err_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Chain model: shifts only while se is high; capture leaves contents unchanged.
    logic [N-1:0] chain = '0;
    logic         sout  = 1'b0;
    always @(posedge clk_i) begin
        if (test_se_o) chain <= {chain[N-2:0], scan_in_o};
        sout <= chain[N-1];
    end
    assign scan_out_i = sout;

    int n_vec = 0, n_mis = 0;
    int widx, n_acc, n_se, n_done, n_capw, cap_bad;
    int first_se, last_se, last_acc, done_cyc, start_cyc;
    logic       busy_after;
    logic [2:0] rdy_t1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic in_bit(input int w);
        int h;
        h = w * 37 + (w >>> 3) * 11 + 5;
        return h[3] ^ h[0];
    endfunction

    // Bit leaving the chain on word w is the one loaded N words earlier.
    function automatic logic exp_bit(input int w);
        return (w < N) ? 1'b1 : in_bit(w - N);
    endfunction

    task automatic drive(input int np, input bit gaps, input int mode, input int total);
        logic e, m;
        pat_valid_i = (widx < total) && (!gaps || ($urandom_range(0, 1) == 1));
        pat_in_i    = in_bit(widx);
        e = exp_bit(widx);
        m = 1'b0;
        if (mode == 2) e = ~e;
        if (mode == 1 && widx == np * N + 3) e = ~e;
        if (mode == 1 && widx == np * N + 5) begin
            e = ~e;
            m = 1'b1;
        end
        pat_exp_i  = e;
        pat_mask_i = m;
    endtask

    task automatic run_sess(input int np, input bit gaps, input int mode, input bit dup,
                            input int stop_at, input int budget);
        int total, gap_len;
        bit prev_rdy, in_gap;
        total = (np + 1) * N;
        widx = 0; n_acc = 0; n_se = 0; n_done = 0; n_capw = 0; cap_bad = 0;
        first_se = -1; last_se = -1; last_acc = -1; done_cyc = -1;
        busy_after = 1'b1; rdy_t1 = '0; prev_rdy = 0; in_gap = 0; gap_len = 0;
        @(posedge clk_i); #1;
        start_i = 1'b1; num_pat_i = np[15:0]; pat_valid_i = 1'b0; start_cyc = cyc;
        forever begin
            @(negedge clk_i);
            if (cyc == start_cyc + 1) rdy_t1 = {busy_o, test_tm_o, pat_ready_o};
            if (pat_valid_i && pat_ready_o) begin
                widx++; n_acc++; last_acc = cyc;
            end
            if (test_se_o) begin
                n_se++;
                if (first_se < 0) first_se = cyc;
                last_se = cyc;
            end
            if (busy_o) begin
                if (pat_ready_o && !prev_rdy && in_gap) begin
                    n_capw++;
                    if (gap_len != CAP) cap_bad++;
                    in_gap = 0;
                end
                if (!pat_ready_o && prev_rdy) begin
                    in_gap = 1; gap_len = 0;
                end
                if (!pat_ready_o && in_gap) gap_len++;
            end
            prev_rdy = pat_ready_o;
            if (done_o) begin
                n_done++; done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                busy_after = busy_o;
                break;
            end
            if (stop_at >= 0 && widx == stop_at) break;
            if (cyc - start_cyc > budget) begin
                chk("timeout", cyc - start_cyc, budget);
                break;
            end
            @(posedge clk_i); #1;
            start_i = dup && (widx == N + 2);
            drive(np, gaps, mode, total);
        end
    endtask

    initial begin
        int seen;
        rstn_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; num_pat_i = '0;
        pat_valid_i = 1'b0; pat_in_i = 1'b0; pat_exp_i = 1'b0; pat_mask_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_outs", {test_tm_o, test_se_o, scan_in_o, pat_ready_o, busy_o, done_o, fail_o, err_cnt_o}, 0);
        rstn_i = 1'b1;

        // gap-free, 2 patterns, with an ignored start mid-session
        run_sess(2, 0, 0, 1, -1, 200);
        chk("start_t1_busy_tm_rdy", rdy_t1, 3'b111);
        chk("first_se_lat", first_se - start_cyc, 2);
        chk("words", n_acc, 24);
        chk("se_high", n_se, 24);
        chk("cap_windows", n_capw, 2);
        chk("cap_len_bad", cap_bad, 0);
        chk("se_low_inside", (last_se - first_se + 1) - n_se, 2 * CAP);
        chk("done_cnt", n_done, 1);
        chk("done_lat", done_cyc - last_acc, OL + 3);
        chk("busy_after_done", busy_after, 0);
        chk("fail_clean", fail_o, 0);
        chk("err_clean", err_cnt_o, 0);

        // random valid gaps
        run_sess(2, 1, 0, 0, -1, 400);
        chk("gap_words", n_acc, 24);
        chk("gap_se_high", n_se, 24);
        chk("gap_cap_bad", cap_bad, 0);
        chk("gap_done_lat", done_cyc - last_acc, OL + 3);
        chk("gap_fail", fail_o, 0);
        chk("gap_err", err_cnt_o, 0);

        // two flipped expecteds in final unload, one masked
        run_sess(2, 0, 1, 0, -1, 200);
        chk("flip_fail", fail_o, 1);
        chk("flip_err", err_cnt_o, 1);

        // zero patterns
        run_sess(0, 0, 0, 0, -1, 50);
        chk("np0_done_lat", done_cyc - start_cyc, 2);
        chk("np0_se", n_se, 0);
        chk("np0_err", err_cnt_o, 0);
        chk("np0_fail", fail_o, 0);

        // abort mid pattern 1
        run_sess(2, 0, 0, 0, N + 3, 200);
        @(posedge clk_i); #1 abort_i = 1'b1;
        @(posedge clk_i); #1 abort_i = 1'b0; pat_valid_i = 1'b0;
        @(negedge clk_i);
        chk("abort_outs", {busy_o, test_se_o, test_tm_o, pat_ready_o}, 0);
        seen = 0;
        repeat (6) begin
            @(negedge clk_i);
            if (done_o) seen++;
        end
        chk("abort_no_done", seen, 0);
        run_sess(2, 0, 0, 0, -1, 200);
        chk("post_abort_words", n_acc, 24);
        chk("post_abort_done", n_done, 1);
        chk("post_abort_err", err_cnt_o, 0);

        // start together with abort in idle
        @(posedge clk_i); #1 start_i = 1'b1; abort_i = 1'b1; num_pat_i = 16'd2;
        @(posedge clk_i); #1 start_i = 1'b0; abort_i = 1'b0;
        @(negedge clk_i);
        chk("start_abort_idle", {busy_o, test_tm_o}, 0);

        // 8192 patterns of all-inverted expecteds: 65536 mismatches
        run_sess(8192, 0, 2, 0, -1, 80000);
        chk("sat_err", err_cnt_o, 16'hFFFF);
        chk("sat_fail", fail_o, 1);
        chk("sat_done", n_done, 1);

        // reset in the middle of pattern 2's shift
        run_sess(2, 0, 2, 0, 2 * N + 3, 200);
        chk("pre_rst_err", err_cnt_o, N);
        chk("pre_rst_busy", busy_o, 1);
        #2 rstn_i = 1'b0;
        #1;
        chk("mid_rst_outs", {test_tm_o, test_se_o, scan_in_o, pat_ready_o, busy_o, done_o, fail_o, err_cnt_o}, 0);
        pat_valid_i = 1'b0;
        @(negedge clk_i) rstn_i = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
